// File: rtl/rsa_io_pkg.sv
// Shared definitions for the RSA host I/O controller.
//   state_t      : controller FSM state encoding
//   BUS_W_DEF    : default host data bus width
//   OP_W_DEF     : default operand / result width
package rsa_io_pkg;

   localparam int BUS_W_DEF = 32;
   localparam int OP_W_DEF  = 128;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_READ  = 3'd4
   } state_t;

endpackage

// File: rtl/rsa_io_edge.sv
// Two-flop synchroniser for an asynchronous host strobe plus rising-edge
// detector.  A pin edge produces a one-cycle rise_o pulse that the consuming
// logic samples on the third clk edge after the pin changed.
//   clk    : clock
//   rstn   : asynchronous active-low reset (all flops cleared)
//   pin_i  : asynchronous strobe from the host
//   rise_o : one-cycle pulse per rising edge of pin_i
module rsa_io_edge (
   input  logic clk,
   input  logic rstn,
   input  logic pin_i,
   output logic rise_o
);

   // [0],[1] are the synchroniser; [2] holds the previous synchronised level.
   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], pin_i};
      end
   end

   assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/rsa_io_ctrl.sv
// Host-side I/O controller for a modular-exponentiation core.  The host
// streams base, exponent and modulus (LSW first each) over a narrow bus using
// an asynchronous write strobe, the core is started, and the result is read
// back one bus word per read strobe.
//
// Optional build feature: define RSA_IO_TIMEOUT_EN to add a watchdog on the
// WAIT state (TIMEOUT_CYC cycles); without it WAIT holds until core_done.
//
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   wr, rd         : asynchronous host write / read-advance strobes
//   clr            : synchronous soft abort (operands are kept)
//   data_i         : host write data
//   data_o         : current result word while reading, else 0
//   busy           : load, start or compute in progress
//   io_end         : result available for readback
//   err            : sticky protocol / timeout error
//   core_start     : one-cycle start pulse to the core
//   core_base/exp/mod : operands to the core
//   core_done      : core completion pulse
//   core_result    : core result, valid with core_done
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for the first operand word
// S_LOAD  | collecting the remaining operand words
// S_START | one cycle, pulses core_start
// S_WAIT  | core computing, waiting for core_done (or watchdog)
// S_READ  | result held, host reads it out word by word
module rsa_io_ctrl
   import rsa_io_pkg::*;
#(
   parameter int BUS_W       = BUS_W_DEF,
   parameter int OP_W        = OP_W_DEF,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr,
   input  logic              rd,
   input  logic              clr,
   input  logic [BUS_W-1:0]  data_i,
   output logic [BUS_W-1:0]  data_o,
   output logic              busy,
   output logic              io_end,
   output logic              err,
   output logic              core_start,
   output logic [OP_W-1:0]   core_base,
   output logic [OP_W-1:0]   core_exp,
   output logic [OP_W-1:0]   core_mod,
   input  logic              core_done,
   input  logic [OP_W-1:0]   core_result
);

   localparam int BEATS  = OP_W / BUS_W;
   localparam int NWORDS = 3 * BEATS;
   localparam int WC_W   = $clog2(NWORDS);
   localparam int RI_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [WC_W-1:0] WC_LAST = WC_W'(NWORDS - 1);
   localparam logic [RI_W-1:0] RI_LAST = RI_W'(BEATS - 1);

   if ((OP_W % BUS_W) != 0 || BEATS < 1) begin : g_bad_width
      $error("rsa_io_ctrl: OP_W must be a non-zero multiple of BUS_W");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("rsa_io_ctrl: TIMEOUT_CYC must be at least 1");
   end

   logic wr_rise;
   logic rd_rise;

   rsa_io_edge u_wr_edge (
      .clk    (clk),
      .rstn   (rstn),
      .pin_i  (wr),
      .rise_o (wr_rise)
   );

   rsa_io_edge u_rd_edge (
      .clk    (clk),
      .rstn   (rstn),
      .pin_i  (rd),
      .rise_o (rd_rise)
   );

   state_t               state_q,  state_d;
   logic [WC_W-1:0]      wcnt_q,   wcnt_d;
   logic [RI_W-1:0]      ridx_q,   ridx_d;
   // Word w of the host stream lands at bits [w*BUS_W +: BUS_W], so the flat
   // vector is {mod, exp, base} with each operand LSW first.
   logic [3*OP_W-1:0]    ops_q,    ops_d;
   logic [OP_W-1:0]      result_q, result_d;
   logic                 err_q,    err_d;

`ifdef RSA_IO_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] tcnt_q, tcnt_d;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         wcnt_q   <= '0;
         ridx_q   <= '0;
         ops_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
`ifdef RSA_IO_TIMEOUT_EN
         tcnt_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         ridx_q   <= ridx_d;
         ops_q    <= ops_d;
         result_q <= result_d;
         err_q    <= err_d;
`ifdef RSA_IO_TIMEOUT_EN
         tcnt_q   <= tcnt_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      ridx_d   = ridx_q;
      ops_d    = ops_q;
      result_d = result_q;
      err_d    = err_q;
`ifdef RSA_IO_TIMEOUT_EN
      tcnt_d   = tcnt_q;
`endif

      if (clr) begin
         state_d = S_IDLE;
         wcnt_d  = '0;
         ridx_d  = '0;
         err_d   = 1'b0;
`ifdef RSA_IO_TIMEOUT_EN
         tcnt_d  = '0;
`endif
      end else begin
         case (state_q)
            // IDLE and LOAD share the capture path; wcnt_q is 0 in IDLE.
            S_IDLE, S_LOAD: begin
               if (wr_rise) begin
                  for (int w = 0; w < NWORDS; w++) begin
                     if (wcnt_q == WC_W'(w)) begin
                        ops_d[w*BUS_W +: BUS_W] = data_i;
                     end
                  end
                  if (wcnt_q == WC_LAST) begin
                     wcnt_d  = '0;
                     state_d = S_START;
                  end else begin
                     wcnt_d  = wcnt_q + WC_W'(1);
                     state_d = S_LOAD;
                  end
               end
            end

            S_START: begin
               if (wr_rise) begin
                  err_d = 1'b1;
               end
               state_d = S_WAIT;
`ifdef RSA_IO_TIMEOUT_EN
               // Down-counter reaches zero on the TIMEOUT_CYC-th WAIT cycle.
               tcnt_d  = TO_W'(TIMEOUT_CYC - 1);
`endif
            end

            S_WAIT: begin
               if (wr_rise) begin
                  err_d = 1'b1;
               end
               if (core_done) begin
                  result_d = core_result;
                  ridx_d   = '0;
                  state_d  = S_READ;
`ifdef RSA_IO_TIMEOUT_EN
                  tcnt_d   = '0;
`endif
               end
`ifdef RSA_IO_TIMEOUT_EN
               else if (tcnt_q == '0) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tcnt_d  = tcnt_q - TO_W'(1);
               end
`endif
            end

            S_READ: begin
               if (wr_rise) begin
                  err_d = 1'b1;
               end
               if (rd_rise) begin
                  if (ridx_q == RI_LAST) begin
                     ridx_d  = '0;
                     state_d = S_IDLE;
                  end else begin
                     ridx_d  = ridx_q + RI_W'(1);
                  end
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      data_o = '0;
      if (state_q == S_READ) begin
         for (int b = 0; b < BEATS; b++) begin
            if (ridx_q == RI_W'(b)) begin
               data_o = result_q[b*BUS_W +: BUS_W];
            end
         end
      end
   end

   assign busy       = (state_q == S_LOAD) || (state_q == S_START) || (state_q == S_WAIT);
   assign io_end     = (state_q == S_READ);
   assign err        = err_q;
   assign core_start = (state_q == S_START);
   assign core_base  = ops_q[0*OP_W +: OP_W];
   assign core_exp   = ops_q[1*OP_W +: OP_W];
   assign core_mod   = ops_q[2*OP_W +: OP_W];

endmodule

// File: tb/tb_rsa_io_ctrl.sv
module tb_rsa_io_ctrl;

   localparam int BW    = 32;
   localparam int OW    = 64;
   localparam int BEATS = OW / BW;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic          clr = 1'b0;
   logic [BW-1:0] data_i = '0;
   logic [BW-1:0] data_o;
   logic          busy;
   logic          io_end;
   logic          err;
   logic          core_start;
   logic [OW-1:0] core_base;
   logic [OW-1:0] core_exp;
   logic [OW-1:0] core_mod;
   logic          core_done = 1'b0;
   logic [OW-1:0] core_result = '0;

   rsa_io_ctrl #(
      .BUS_W       (BW),
      .OP_W        (OW),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .wr          (wr),
      .rd          (rd),
      .clr         (clr),
      .data_i      (data_i),
      .data_o      (data_o),
      .busy        (busy),
      .io_end      (io_end),
      .err         (err),
      .core_start  (core_start),
      .core_base   (core_base),
      .core_exp    (core_exp),
      .core_mod    (core_mod),
      .core_done   (core_done),
      .core_result (core_result)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int start_cnt = 0;

   always @(negedge clk) begin
      if (core_start === 1'b1) start_cnt++;
   end

   typedef struct packed {
      logic [5:0][31:0] w;
      logic [63:0]      res;
      logic [63:0]      eb;
      logic [63:0]      ee;
      logic [63:0]      em;
      logic [31:0]      d0;
      logic [31:0]      d1;
   } vec_t;

   vec_t vecs [3];

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr_word(input logic [31:0] d);
      data_i = d;
      wr = 1'b1;
      tick(4);
      wr = 1'b0;
      tick(3);
   endtask

   task automatic rd_pulse();
      rd = 1'b1;
      tick(4);
      rd = 1'b0;
      tick(3);
   endtask

   task automatic done_pulse(input logic [63:0] res);
      core_result = res;
      core_done = 1'b1;
      tick(1);
      core_done = 1'b0;
      tick(1);
   endtask

   task automatic load6(input logic [5:0][31:0] w);
      for (int i = 0; i < 6; i++) wr_word(w[i]);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
   endtask

   initial begin
      int s0;
      logic [31:0] q[$];
      logic [63:0] m_res;
      logic        m_err;

      vecs[0] = '{w: {32'd0, 32'd497, 32'd0, 32'd13, 32'd0, 32'd4},
                  res: 64'd445, eb: 64'd4, ee: 64'd13, em: 64'd497,
                  d0: 32'h1BD, d1: 32'h0};
      vecs[1] = '{w: {32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000003,
                      32'h01234567, 32'h89ABCDEF},
                  res: 64'hDEADBEEF_CAFEF00D,
                  eb: 64'h01234567_89ABCDEF, ee: 64'h00000001_00000003,
                  em: 64'h80000000_FFFFFFFF,
                  d0: 32'hCAFEF00D, d1: 32'hDEADBEEF};
      vecs[2] = '{w: {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
                  res: 64'h00000007_00000008,
                  eb: 64'h00000002_00000001, ee: 64'h00000004_00000003,
                  em: 64'h00000006_00000005,
                  d0: 32'd8, d1: 32'd7};

      // Reset state
      tick(3);
      chk("rst_data_o", data_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_io_end", io_end, 0);
      chk("rst_err", err, 0);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_base", core_base, 0);
      rstn = 1'b1;
      tick(2);

      // Table-driven full transactions
      for (int v = 0; v < 3; v++) begin
         s0 = start_cnt;
         load6(vecs[v].w);
         chk($sformatf("v%0d_start_once", v), start_cnt - s0, 1);
         chk($sformatf("v%0d_busy_wait", v), busy, 1);
         chk($sformatf("v%0d_base", v), core_base, vecs[v].eb);
         chk($sformatf("v%0d_exp", v), core_exp, vecs[v].ee);
         chk($sformatf("v%0d_mod", v), core_mod, vecs[v].em);
         done_pulse(vecs[v].res);
         chk($sformatf("v%0d_io_end", v), io_end, 1);
         chk($sformatf("v%0d_busy_read", v), busy, 0);
         chk($sformatf("v%0d_d0", v), data_o, vecs[v].d0);
         rd_pulse();
         chk($sformatf("v%0d_d1", v), data_o, vecs[v].d1);
         chk($sformatf("v%0d_io_end_mid", v), io_end, 1);
         rd_pulse();
         chk($sformatf("v%0d_io_end_done", v), io_end, 0);
         chk($sformatf("v%0d_idle", v), busy, 0);
         chk($sformatf("v%0d_data_o_idle", v), data_o, 0);
         chk($sformatf("v%0d_err", v), err, 0);
      end

      // wr during WAIT sets err, operands unchanged, flow completes
      load6(vecs[0].w);
      wr_word(32'h5555AAAA);
      chk("wwait_err", err, 1);
      chk("wwait_busy", busy, 1);
      chk("wwait_base", core_base, 64'd4);
      chk("wwait_exp", core_exp, 64'd13);
      chk("wwait_mod", core_mod, 64'd497);
      done_pulse(64'd445);
      chk("wwait_io_end", io_end, 1);
      chk("wwait_d0", data_o, 32'h1BD);
      rd_pulse();
      rd_pulse();
      chk("wwait_idle", {busy, io_end}, 0);
      chk("wwait_err_sticky", err, 1);

      // clr mid-load then full reload
      wr_word(32'd9);
      wr_word(32'd9);
      wr_word(32'd9);
      do_clr();
      chk("clr_idle", busy, 0);
      chk("clr_err", err, 0);
      load6({32'd0, 32'd13, 32'd0, 32'd5, 32'd0, 32'd2});
      chk("clr_base", core_base, 64'd2);
      chk("clr_exp", core_exp, 64'd5);
      chk("clr_mod", core_mod, 64'd13);
      chk("clr_err2", err, 0);
      do_clr();
      chk("clr_abort_wait", busy, 0);
      chk("clr_keeps_ops", core_mod, 64'd13);

      // rd edges in IDLE and LOAD are ignored
      rd_pulse();
      chk("rd_idle_busy", busy, 0);
      chk("rd_idle_io_end", io_end, 0);
      chk("rd_idle_err", err, 0);
      chk("rd_idle_data", data_o, 0);
      wr_word(32'd1);
      wr_word(32'd2);
      rd_pulse();
      chk("rd_load_busy", busy, 1);
      chk("rd_load_err", err, 0);
      chk("rd_load_data", data_o, 0);
      do_clr();

      // Reset during WAIT, late core_done ignored
      load6(vecs[1].w);
      chk("rstw_busy", busy, 1);
      rstn = 1'b0;
      tick(2);
      chk("rstw_base_zero", core_base, 0);
      chk("rstw_busy_zero", busy, 0);
      rstn = 1'b1;
      tick(1);
      done_pulse(64'd123);
      chk("rstw_io_end", io_end, 0);
      chk("rstw_idle", busy, 0);
      chk("rstw_data", data_o, 0);

      // Watchdog behaviour
      load6(vecs[2].w);
`ifdef RSA_IO_TIMEOUT_EN
      tick(120);
      chk("to_err", err, 1);
      chk("to_idle", busy, 0);
      chk("to_io_end", io_end, 0);
`else
      tick(1000);
      chk("nto_still_wait", busy, 1);
      chk("nto_err", err, 0);
      chk("nto_io_end", io_end, 0);
`endif
      do_clr();

      // Randomised transactions against a word-stream model
      m_err = 1'b0;
      for (int it = 0; it < 10; it++) begin
         q = {};
         for (int i = 0; i < 6; i++) q.push_back($urandom);
         m_res = {$urandom, $urandom};
         if ($urandom_range(0, 2) == 0) rd_pulse();
         s0 = start_cnt;
         for (int i = 0; i < 6; i++) wr_word(q[i]);
         if ($urandom_range(0, 2) == 0) begin
            wr_word($urandom);
            m_err = 1'b1;
         end
         chk($sformatf("r%0d_start", it), start_cnt - s0, 1);
         chk($sformatf("r%0d_base", it), core_base, {q[1], q[0]});
         chk($sformatf("r%0d_exp", it), core_exp, {q[3], q[2]});
         chk($sformatf("r%0d_mod", it), core_mod, {q[5], q[4]});
         done_pulse(m_res);
         for (int b = 0; b < BEATS; b++) begin
            chk($sformatf("r%0d_word%0d", it, b), data_o, 32'(m_res >> (BW * b)));
            chk($sformatf("r%0d_io_end%0d", it, b), io_end, 1);
            rd_pulse();
         end
         chk($sformatf("r%0d_idle", it), {busy, io_end}, 0);
         chk($sformatf("r%0d_err", it), err, m_err);
         if ($urandom_range(0, 1) == 0) begin
            do_clr();
            m_err = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
